// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB (valid/tag/target) plus a
// 2-bit saturating-counter PHT, with EX-side mispredict/recovery outputs and
// saturating statistics counters.
// Optional build macro GSHARE_EN: PHT index is XORed with a global history
// register that is updated on every resolved branch.
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8,
    parameter int GHR_BITS   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_IF,
    output logic        predTaken_IF,
    output logic [31:0] predTarget_IF,
    input  logic        update_EX,
    input  logic [31:0] pc_EX,
    input  logic        taken_EX,
    input  logic [31:0] target_EX,
    input  logic        predTaken_EX,
    input  logic [31:0] predTarget_EX,
    output logic        mispredict_EX,
    output logic [31:0] recoverPC_EX,
    output logic [31:0] branchCount,
    output logic [31:0] mispredCount
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        else       return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

    // 32-bit increment that sticks at all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic                  valid_q  [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [31:0]           target_q [ENTRIES];
    logic [1:0]            pht_q    [ENTRIES];
    logic [31:0]           branch_cnt_q, branch_cnt_d;
    logic [31:0]           mispred_cnt_q, mispred_cnt_d;

    logic [INDEX_BITS-1:0] idx_if, idx_ex, pidx_if, pidx_ex;
    logic [TAG_BITS-1:0]   tag_if, tag_ex;
    logic                  hit_if, hit_ex;
    logic                  btb_we, pht_we;
    logic [1:0]            pht_wdata;

    assign idx_if = pc_IF[INDEX_BITS+1:2];
    assign idx_ex = pc_EX[INDEX_BITS+1:2];
    assign tag_if = pc_IF[TAG_HI:TAG_LO];
    assign tag_ex = pc_EX[TAG_HI:TAG_LO];
    assign hit_if = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
    assign hit_ex = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);

`ifdef GSHARE_EN
    logic [GHR_BITS-1:0]   ghr_q, ghr_d;
    logic [INDEX_BITS-1:0] ghr_ext;

    assign ghr_ext = INDEX_BITS'(ghr_q);
    assign pidx_if = idx_if ^ ghr_ext;
    assign pidx_ex = idx_ex ^ ghr_ext;
    assign ghr_d   = update_EX ? {ghr_q[GHR_BITS-2:0], taken_EX} : ghr_q;

    // Global history shifts in every resolved outcome.
    always_ff @(posedge clk) begin
        if (reset) ghr_q <= '0;
        else       ghr_q <= ghr_d;
    end

    // PHT trains on every resolution; allocation leaves the counter alone.
    always_comb begin
        pht_we    = update_EX;
        pht_wdata = ctr_step(pht_q[pidx_ex], taken_EX);
    end
`else
    localparam int unused_ghr_bits = GHR_BITS;

    assign pidx_if = idx_if;
    assign pidx_ex = idx_ex;

    // PHT trains on a tag hit; a taken miss allocates as weakly taken.
    always_comb begin
        pht_we    = update_EX && (hit_ex || taken_EX);
        pht_wdata = hit_ex ? ctr_step(pht_q[pidx_ex], taken_EX) : 2'b10;
    end
`endif

    // Taken resolutions either refresh a hitting entry or replace the slot.
    assign btb_we = update_EX && taken_EX;

    assign predTaken_IF  = hit_if && pht_q[pidx_if][1];
    assign predTarget_IF = predTaken_IF ? target_q[idx_if] : pc_IF + 32'd4;

    assign mispredict_EX = update_EX && ((taken_EX != predTaken_EX) ||
                           (taken_EX && predTaken_EX && (target_EX != predTarget_EX)));
    assign recoverPC_EX  = !update_EX ? 32'd0 : (taken_EX ? target_EX : pc_EX + 32'd4);

    // Statistics advance once per resolution, saturating.
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (update_EX) begin
            branch_cnt_d = sat_inc(branch_cnt_q);
            if (mispredict_EX) mispred_cnt_d = sat_inc(mispred_cnt_q);
        end
    end

    // Control state: valid bits, PHT counters and statistics are reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                pht_q[i]   <= 2'b01;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (btb_we) valid_q[idx_ex]  <= 1'b1;
            if (pht_we) pht_q[pidx_ex]   <= pht_wdata;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // BTB payload is qualified by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (btb_we && !reset) begin
            tag_q[idx_ex]    <= tag_ex;
            target_q[idx_ex] <= target_EX;
        end
    end

    assign branchCount  = branch_cnt_q;
    assign mispredCount = mispred_cnt_q;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_IF[1:0], pc_IF[31:TAG_HI+1], pc_EX[1:0], pc_EX[31:TAG_HI+1]};
endmodule
